// File: rtl/rom_ctrl_exp_digest_fetch.sv
// Fetches the expected ROM digest from the top NumWords words of ROM and
// hands it to the digest comparator, together with a one-cycle start pulse.
//
// Ports:
//   clk_i, rst_ni       clock, synchronous active-low reset
//   start_i             begin fetch (honoured only in Idle)
//   rom_req_o/addr_o    read request and word address
//   rom_gnt_i           request accepted this cycle
//   rom_rvalid_i/rdata  in-order read responses
//   exp_digest_o        assembled digest, word 0 as LSB
//   done_o              level, high in Done
//   cmp_start_o         one-cycle pulse on entry to Done
//   alert_o             combinational alert level
//
// Optional feature: define ROM_CTRL_FETCH_TIMEOUT_EN to add a response
// watchdog that raises a sticky alert after 255 cycles without a response.
module rom_ctrl_exp_digest_fetch #(
  parameter int unsigned NumWords = 8,
  parameter int unsigned RomDepth = 8192,
  localparam int unsigned AW = (RomDepth > 1) ? $clog2(RomDepth) : 1
) (
  input  logic                     clk_i,
  input  logic                     rst_ni,
  input  logic                     start_i,
  output logic                     rom_req_o,
  output logic [AW-1:0]            rom_addr_o,
  input  logic                     rom_gnt_i,
  input  logic                     rom_rvalid_i,
  input  logic [31:0]              rom_rdata_i,
  output logic [NumWords*32-1:0]   exp_digest_o,
  output logic                     done_o,
  output logic                     cmp_start_o,
  output logic                     alert_o
);

  localparam int unsigned IW   = $clog2(NumWords + 1);
  localparam int unsigned DW   = NumWords * 32;
  localparam int unsigned BASE = RomDepth - NumWords;

  // Sparse encoding, pairwise Hamming distance >= 3
  localparam logic [4:0] ST_IDLE  = 5'b01011;
  localparam logic [4:0] ST_FETCH = 5'b10110;
  localparam logic [4:0] ST_DONE  = 5'b01100;

  logic [4:0]    r_state;
  logic [4:0]    w_state_next;
  logic          w_fsm_err;
  logic [IW-1:0] r_req_idx;
  logic [IW-1:0] r_rsp_idx;
  logic [1:0]    r_outstanding;
  logic [DW-1:0] r_digest;
  logic          r_cmp_start;
  logic          w_req;
  logic          w_gnt_fire;
  logic          w_rsp_fire;
  logic          w_last_rsp;
  logic          w_timeout;

  // Request depends only on registered state, never on gnt/rvalid
  assign w_req      = (r_state == ST_FETCH) && (r_req_idx < IW'(NumWords)) &&
                      (r_outstanding < 2'd2);
  assign w_gnt_fire = w_req && rom_gnt_i;
  assign w_rsp_fire = rom_rvalid_i && (r_outstanding != 2'd0);
  assign w_last_rsp = w_rsp_fire && (r_rsp_idx == IW'(NumWords - 1));

  // Next-state logic; unknown encodings stay put and flag an error
  always_comb begin
    w_state_next = r_state;
    w_fsm_err    = 1'b0;
    case (r_state)
      ST_IDLE:  if (start_i) w_state_next = ST_FETCH;
      ST_FETCH: if (w_last_rsp) w_state_next = ST_DONE;
      ST_DONE:  w_state_next = ST_DONE;
      default:  w_fsm_err = 1'b1;
    endcase
  end

  // State register and entry pulse for the comparator
  always_ff @(posedge clk_i) begin
    if (!rst_ni) begin
      r_state     <= ST_IDLE;
      r_cmp_start <= 1'b0;
    end else begin
      r_state     <= w_state_next;
      r_cmp_start <= (w_state_next == ST_DONE) && (r_state != ST_DONE);
    end
  end

  // Request / response bookkeeping
  always_ff @(posedge clk_i) begin
    if (!rst_ni) begin
      r_req_idx     <= '0;
      r_rsp_idx     <= '0;
      r_outstanding <= 2'd0;
    end else begin
      if (w_gnt_fire) r_req_idx <= r_req_idx + IW'(1);
      if (w_rsp_fire) r_rsp_idx <= r_rsp_idx + IW'(1);
      case ({w_gnt_fire, w_rsp_fire})
        2'b10:   r_outstanding <= r_outstanding + 2'd1;
        2'b01:   r_outstanding <= r_outstanding - 2'd1;
        default: r_outstanding <= r_outstanding;
      endcase
    end
  end

  // Digest assembly; frozen once Done is reached
  always_ff @(posedge clk_i) begin
    if (!rst_ni) begin
      r_digest <= '0;
    end else begin
      for (int unsigned i = 0; i < NumWords; i++) begin
        if (w_rsp_fire && (r_state != ST_DONE) && (r_rsp_idx == IW'(i))) begin
          r_digest[i*32 +: 32] <= rom_rdata_i;
        end
      end
    end
  end

`ifdef ROM_CTRL_FETCH_TIMEOUT_EN
  logic [7:0] r_wdog;
  logic       r_timeout;

  // Watchdog on missing responses; the resulting alert is sticky until reset
  always_ff @(posedge clk_i) begin
    if (!rst_ni) begin
      r_wdog    <= 8'd0;
      r_timeout <= 1'b0;
    end else begin
      if ((r_state == ST_IDLE) || rom_rvalid_i) begin
        r_wdog <= 8'd0;
      end else if ((r_outstanding != 2'd0) && (r_wdog != 8'hFF)) begin
        r_wdog <= r_wdog + 8'd1;
      end
      if (r_wdog == 8'hFF) r_timeout <= 1'b1;
    end
  end

  assign w_timeout = r_timeout;
`else
  assign w_timeout = 1'b0;
`endif

  assign rom_req_o    = w_req;
  // Address forced to zero when idle so the port is quiet outside requests
  assign rom_addr_o   = w_req ? AW'(BASE + 32'(r_req_idx)) : '0;
  assign exp_digest_o = r_digest;
  assign done_o       = (r_state == ST_DONE);
  assign cmp_start_o  = r_cmp_start;

  assign alert_o = w_fsm_err ||
                   (start_i && (r_state != ST_IDLE)) ||
                   (rom_rvalid_i && (r_outstanding == 2'd0)) ||
                   ((r_state == ST_DONE) &&
                    ((r_rsp_idx != IW'(NumWords)) || (r_outstanding != 2'd0))) ||
                   w_timeout;

endmodule

// File: tb/tb_rom_ctrl_exp_digest_fetch.sv
module tb_rom_ctrl_exp_digest_fetch;

  localparam int unsigned N     = 8;
  localparam int unsigned DEPTH = 8192;
  localparam int unsigned AW    = 13;
  localparam int unsigned DW    = N * 32;
  localparam int unsigned BASE  = DEPTH - N;

  logic          clk = 1'b0;
  logic          rst_ni = 1'b0;
  logic          start_i = 1'b0;
  logic          rom_req_o;
  logic [AW-1:0] rom_addr_o;
  logic          rom_gnt_i = 1'b1;
  logic          rom_rvalid_i = 1'b0;
  logic [31:0]   rom_rdata_i = 32'd0;
  logic [DW-1:0] exp_digest_o;
  logic          done_o;
  logic          cmp_start_o;
  logic          alert_o;

  always #5 clk = ~clk;

  rom_ctrl_exp_digest_fetch #(.NumWords(N), .RomDepth(DEPTH)) dut (
    .clk_i        (clk),
    .rst_ni       (rst_ni),
    .start_i      (start_i),
    .rom_req_o    (rom_req_o),
    .rom_addr_o   (rom_addr_o),
    .rom_gnt_i    (rom_gnt_i),
    .rom_rvalid_i (rom_rvalid_i),
    .rom_rdata_i  (rom_rdata_i),
    .exp_digest_o (exp_digest_o),
    .done_o       (done_o),
    .cmp_start_o  (cmp_start_o),
    .alert_o      (alert_o)
  );

  int errors = 0;
  int checks = 0;
  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  typedef struct {
    logic [DW-1:0] dig;
    int            cyc;
  } exp_t;

  logic [AW-1:0] addr_q[$];
  exp_t          dig_q[$];
  exp_t          mon_e;

  // Stimulus-owned control flags read by the ROM responder
  logic        flush = 1'b0;
  logic        withhold = 1'b0;
  logic        release_one = 1'b0;
  logic        spur_req = 1'b0;
  logic        stall_en = 1'b0;
  logic        mon_en = 1'b0;
  logic [31:0] data_base = 32'd0;

  // Responder-owned state
  logic [31:0] rsp_q[$];
  int          stall_cnt = 0;
  int          deliv_cnt = 0;

  task automatic chk(input string name, input logic [DW-1:0] act, input logic [DW-1:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // ROM model: in-order responses one cycle after grant, optional stall/withhold
  initial begin
    forever begin
      @(posedge clk); #1;
      rom_rvalid_i = 1'b0;
      rom_rdata_i  = 32'd0;
      if (flush) begin
        rsp_q.delete();
        stall_cnt = 0;
      end else if (spur_req) begin
        rom_rvalid_i = 1'b1;
        rom_rdata_i  = 32'hDEADBEEF;
      end else if ((!withhold || release_one) && rsp_q.size() > 0) begin
        rom_rvalid_i = 1'b1;
        rom_rdata_i  = rsp_q.pop_front();
        deliv_cnt++;
      end
      if (stall_en && rom_req_o && rom_addr_o == AW'(BASE + 2) && stall_cnt < 3) begin
        rom_gnt_i = 1'b0;
        stall_cnt++;
      end else begin
        rom_gnt_i = 1'b1;
      end
      @(negedge clk);
      if (rom_req_o && rom_gnt_i) rsp_q.push_back(data_base + 32'(rom_addr_o) - 32'(BASE));
    end
  end

  // Monitor: checks granted/stalled addresses and the digest at cmp_start
  initial begin
    forever begin
      @(negedge clk);
      if (mon_en) begin
        if (rom_req_o && rom_gnt_i) begin
          if (addr_q.size() == 0) begin
            checks++; errors++;
            $display("FAIL addr_unexpected: got %0d expected no request", rom_addr_o);
          end else begin
            chk("addr", DW'(rom_addr_o), DW'(addr_q.pop_front()));
          end
        end else if (rom_req_o && addr_q.size() > 0) begin
          chk("addr_hold", DW'(rom_addr_o), DW'(addr_q[0]));
        end
        if (cmp_start_o) begin
          if (dig_q.size() == 0) begin
            checks++; errors++;
            $display("FAIL cmp_start_unexpected: got pulse expected none");
          end else begin
            mon_e = dig_q.pop_front();
            chk("digest", exp_digest_o, mon_e.dig);
            chk("done_at_cmp", DW'(done_o), DW'(1));
            if (mon_e.cyc > 0) chk("cmp_cycle", DW'(cyc), DW'(mon_e.cyc));
          end
        end
      end
    end
  end

  task automatic tick();
    @(posedge clk); #2;
  endtask

  task automatic do_reset();
    mon_en = 1'b0; flush = 1'b1; rst_ni = 1'b0; start_i = 1'b0;
    tick(); tick();
    rst_ni = 1'b1; flush = 1'b0;
    withhold = 1'b0; release_one = 1'b0; stall_en = 1'b0; spur_req = 1'b0;
    addr_q.delete(); dig_q.delete();
    mon_en = 1'b1;
  endtask

  // Issues start_i for one cycle and queues the expected addresses/digest
  task automatic run_start(input logic [31:0] base, input int extra, input bit chk_cyc,
                           output logic [DW-1:0] d);
    exp_t e;
    d = '0;
    data_base = base;
    for (int i = 0; i < N; i++) begin
      addr_q.push_back(AW'(BASE + i));
      d[i*32 +: 32] = base + 32'(i);
    end
    start_i = 1'b1;
    e.dig = d;
    e.cyc = chk_cyc ? cyc + N + 2 + extra : 0;
    dig_q.push_back(e);
    tick();
    start_i = 1'b0;
  endtask

  task automatic wait_done_and_check(input logic [DW-1:0] d);
    for (int k = 0; k < 100; k++) begin
      @(negedge clk);
      if (done_o) break;
    end
    chk("done_reached", DW'(done_o), DW'(1));
    repeat (2) @(negedge clk);
    chk("done_level", DW'(done_o), DW'(1));
    chk("cmp_single", DW'(cmp_start_o), DW'(0));
    chk("alert_done", DW'(alert_o), DW'(0));
    chk("digest_frozen", exp_digest_o, d);
    chk("dig_q_drained", DW'(dig_q.size()), DW'(0));
  endtask

  logic [DW-1:0] dexp;

  initial begin
    do_reset();
    @(negedge clk);
    chk("rst_req", DW'(rom_req_o), DW'(0));
    chk("rst_addr", DW'(rom_addr_o), DW'(0));
    chk("rst_done", DW'(done_o), DW'(0));
    chk("rst_cmp", DW'(cmp_start_o), DW'(0));
    chk("rst_alert", DW'(alert_o), DW'(0));
    chk("rst_digest", exp_digest_o, DW'(0));

    // Best case
    tick();
    run_start(32'h0000_1000, 0, 1'b1, dexp);
    wait_done_and_check(dexp);

    // Three-cycle grant stall on word 2
    do_reset();
    stall_en = 1'b1;
    run_start(32'hA5A5_0000, 3, 1'b1, dexp);
    wait_done_and_check(dexp);

    // Two outstanding, responses withheld
    do_reset();
    withhold = 1'b1;
    run_start(32'h0BAD_F000, 0, 1'b0, dexp);
    repeat (3) @(negedge clk);
    chk("blocked_req", DW'(rom_req_o), DW'(0));
    chk("two_pending", DW'(rsp_q.size()), DW'(2));
    release_one = 1'b1;
    @(negedge clk);
    release_one = 1'b0;
    chk("rsp_cycle_req", DW'(rom_req_o), DW'(0));
    chk("rsp_cycle_rvalid", DW'(rom_rvalid_i), DW'(1));
    @(negedge clk);
    chk("req_reassert", DW'(rom_req_o), DW'(1));
    withhold = 1'b0;
    wait_done_and_check(dexp);

    // Spurious response in Idle, then start_i pulsed during Fetch
    do_reset();
    @(negedge clk);
    spur_req = 1'b1;
    @(negedge clk);
    spur_req = 1'b0;
    chk("alert_spur", DW'(alert_o), DW'(1));
    chk("spur_no_write", exp_digest_o, DW'(0));
    @(negedge clk);
    chk("alert_clear", DW'(alert_o), DW'(0));
    tick();
    run_start(32'h5000_0000, 0, 1'b1, dexp);
    tick();
    start_i = 1'b1;
    @(negedge clk);
    chk("alert_start_fetch", DW'(alert_o), DW'(1));
    tick();
    start_i = 1'b0;
    wait_done_and_check(dexp);

    // Reset after four words captured
    do_reset();
    begin
      int d0;
      d0 = deliv_cnt;
      run_start(32'h0000_2000, 0, 1'b0, dexp);
      for (int k = 0; k < 50; k++) begin
        @(negedge clk);
        if (deliv_cnt - d0 >= 4) break;
      end
      chk("four_words", DW'(deliv_cnt - d0), DW'(4));
    end
    tick();
    rst_ni = 1'b0;
    tick();
    rst_ni = 1'b1;
    @(negedge clk);
    chk("mid_rst_done", DW'(done_o), DW'(0));
    chk("mid_rst_req", DW'(rom_req_o), DW'(0));
    chk("mid_rst_digest", exp_digest_o, DW'(0));
    chk("late_rvalid_alert", DW'(alert_o), DW'(1));
    addr_q.delete(); dig_q.delete();
    @(negedge clk);
    chk("late_alert_clear", DW'(alert_o), DW'(0));
    tick();
    run_start(32'h0000_3000, 0, 1'b1, dexp);
    wait_done_and_check(dexp);

    // Responses withheld for a long time
    do_reset();
    withhold = 1'b1;
    run_start(32'h0000_7000, 0, 1'b0, dexp);
    repeat (300) @(negedge clk);
`ifdef ROM_CTRL_FETCH_TIMEOUT_EN
    chk("timeout_alert", DW'(alert_o), DW'(1));
    @(negedge clk);
    chk("timeout_sticky", DW'(alert_o), DW'(1));
`else
    chk("no_timeout_alert", DW'(alert_o), DW'(0));
`endif
    chk("stuck_not_done", DW'(done_o), DW'(0));
    chk("stuck_no_req", DW'(rom_req_o), DW'(0));
    do_reset();
    @(negedge clk);
    chk("alert_after_reset", DW'(alert_o), DW'(0));

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL global_timeout: got no finish expected finish");
    $fatal(1, "timeout");
  end

endmodule
